// File: rtl/rr_arbiter8.sv
// Registered 8-requester round-robin arbiter with sticky grants.
// Optional hold limit compiled in with RR_ARBITER8_TIMEOUT_EN (parameter MAX_HOLD).
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       any_req
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] w_cand;
  logic [3:0] w_pick;
  logic       w_release;
  logic       w_timeout;
  logic       w_new;

  // {found, index} of the first set bit searching v from p upward, mod 8
  function automatic logic [3:0] pick_first(input logic [7:0] v, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] ix;
    res = '0;
    for (int j = 7; j >= 0; j--) begin
      ix = p + 3'(j);
      if (v[ix]) res = {1'b1, ix};
    end
    return res;
  endfunction

  assign any_req = |req;

  // Owner is masked out; on release its bit is already low, when idle gnt is 0
  assign w_cand    = req & ~gnt;
  assign w_pick    = pick_first(w_cand, r_ptr);
  assign w_release = (r_state == S_GRANT) && !req[gnt_id];
  assign w_new     = w_pick[3] && ((r_state == S_IDLE) || w_release || w_timeout);

`ifdef RR_ARBITER8_TIMEOUT_EN
  logic [7:0] r_cnt;

  assign w_timeout = (r_state == S_GRANT) && (r_cnt == 8'(MAX_HOLD - 1)) && (|w_cand);

  // Saturates at MAX_HOLD-1 so a lone owner keeps the grant indefinitely
  always_ff @(posedge clk) begin
    if (reset || w_new)
      r_cnt <= '0;
    else if (r_state == S_GRANT && r_cnt != 8'(MAX_HOLD - 1))
      r_cnt <= r_cnt + 8'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else if (w_new) begin
      r_state   <= S_GRANT;
      r_ptr     <= w_pick[2:0] + 3'd1;
      gnt       <= 8'd1 << w_pick[2:0];
      gnt_id    <= w_pick[2:0];
      gnt_valid <= 1'b1;
    end else if (r_state == S_GRANT && w_release) begin
      r_state   <= S_IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: driver queues hand-computed grants, monitor checks each cycle.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       any_req;

`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .any_req(any_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic       any;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   vec = 0;

  function automatic logic [2:0] id_of(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string name, input int tag, input logic [7:0] act, input logic [7:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s vec%0d: got %h want %h", name, tag, act, want);
  endtask

  // Drive one cycle of inputs; expected outputs are those after the coming edge
  task automatic step(input logic r, input logic [7:0] q, input logic [7:0] g);
    exp_t e;
    @(negedge clk);
    reset = r;
    req   = q;
    e.gnt = g;
    e.any = (q != 8'h00);
    e.tag = vec++;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt",       e.tag, gnt, e.gnt);
        chk("gnt_id",    e.tag, {5'b0, gnt_id}, {5'b0, id_of(e.gnt)});
        chk("gnt_valid", e.tag, {7'b0, gnt_valid}, {7'b0, (e.gnt != 8'h00)});
        chk("any_req",   e.tag, {7'b0, any_req}, {7'b0, e.any});
      end
    end
  end

  initial begin : driver
    // reset with all requests high
    step(1, 8'hFF, 8'h00);
    step(1, 8'hFF, 8'h00);
    step(0, 8'h00, 8'h00);
    // single request, then drop
    step(0, 8'h10, 8'h10);
    step(0, 8'h00, 8'h00);
    // fairness: ptr=5, req=05 -> 0, then 2, then 0 with no bubble
    step(0, 8'h05, 8'h01);
    step(0, 8'h05, 8'h01);
    step(0, 8'h04, 8'h04);
    step(0, 8'h05, 8'h04);
    step(0, 8'h05, 8'h04);
    step(0, 8'h01, 8'h01);
    step(0, 8'h00, 8'h00);
    // pointer wrap: master 7 not preempted, then ptr=0 picks master 0 over 1
    step(0, 8'h80, 8'h80);
    step(0, 8'h81, 8'h80);
    step(0, 8'h03, 8'h01);
    step(0, 8'h00, 8'h00);
    // mid-grant reset: ptr returns to 0 so master 1 wins again
    step(0, 8'h06, 8'h02);
    step(1, 8'h06, 8'h00);
    step(0, 8'h06, 8'h02);
    step(0, 8'h00, 8'h00);
    // hold limit (MAX_HOLD=4) or indefinite hold
    for (int i = 0; i < 8; i++) step(0, 8'h03, (TO && i >= 4) ? 8'h02 : 8'h01);
    for (int i = 0; i < 8; i++) step(0, 8'h01, 8'h01);
    step(0, 8'h03, TO ? 8'h02 : 8'h01);
    step(0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Registered 8-requester round-robin arbiter that shares one Hack-side resource, such as the memory-mapped bus or the screen/keyboard port, between up to eight masters. It reduces the request vector to an any-request flag, selects one requester per arbitration with a rotating priority pointer, and holds the grant until the owner releases it. An optional hold limit forces rotation so that no single master can starve the others.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held while another request is pending. Legal range 2..255. Used only when the timeout feature is compiled in.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  8  level request per master; bit i = master i
- gnt  output  8  registered one-hot grant; all zeros when idle
- gnt_id  output  3  registered index of the granted master; 0 when idle
- gnt_valid  output  1  registered; 1 exactly when gnt is non-zero
- any_req  output  1  combinational OR of all req bits; 0 only when req == 8'b0

## Operation
- States:
  - IDLE: gnt = 0.
  - GRANT: exactly one gnt bit set.
- Priority pointer ptr[2:0]:
  - Search order is ptr, ptr+1, …, ptr+7, all mod 8.
  - The first set req bit in that order wins.
  - On every new grant to master k, ptr becomes (k+1) mod 8.
- IDLE → GRANT: at the edge where any_req = 1; the winner is chosen from req sampled at that edge.
- GRANT(k), req[k] = 1: grant is held (subject to the hold limit below).
- GRANT(k), req[k] = 0 (release):
  - If any other req bit is set, grant moves to the next winner at the same edge, with no idle bubble.
  - Otherwise go to IDLE.
- Requests from non-owners never preempt the owner except through the hold limit.
- Simultaneous release by the owner and new requests: the winner is taken from the current req using the updated-after-grant ptr.
- gnt_id and gnt_valid always agree with gnt. gnt is never multi-hot.
- Reset (synchronous, at any time, including mid-grant): next edge gives state IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, ptr = 0, hold counter = 0. any_req keeps following req.

## Timing
- Request-to-grant latency: 1 cycle from idle. req[i] first high before edge N gives gnt[i] = 1 after edge N.
- Release-to-handover latency: 1 cycle. req[k] low before edge M means gnt[k] drops after edge M, and the new grant (if any) appears after the same edge.
- A request dropped before it is granted is simply never granted. There is no queueing.
- Grant width per owner: at least 1 cycle.
- any_req has zero latency (combinational).

## Configuration
- RR_ARBITER8_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle the same owner keeps the grant.
  - When the counter equals MAX_HOLD-1 and any other req bit is set, the next edge rotates the grant to the next winner (searching from ptr, owner excluded). This happens even if req[k] is still high.
  - If no other request is pending, the owner keeps the grant and the counter saturates at MAX_HOLD-1.
- RR_ARBITER8_TIMEOUT_EN undefined:
  - No counter is built and MAX_HOLD is ignored.
  - Grant is held until the owner releases it.

## Test plan
- Reset:
  - Stimulus: reset = 1 for 2 cycles with req = 8'hFF.
  - Required response: gnt = 0, gnt_id = 0, gnt_valid = 0 throughout; any_req = 1.
- Single request:
  - Stimulus: req = 8'h10 from idle.
  - Required response: gnt = 8'h10, gnt_id = 4 after one edge. Drop req and gnt returns to 0 one edge later.
- Round-robin fairness:
  - Stimulus: req = 8'h05 held. Each owner drops its bit for one cycle after holding the grant for 2 cycles.
  - Required response: grant sequence 8'h01, 8'h04, 8'h01, with no idle cycle between owners.
- Pointer wrap:
  - Stimulus: master 7 granted and released while req = 8'h81.
  - Required response: next grant goes to master 0, with ptr wrapping to 0.
- Mid-grant reset:
  - Stimulus: reset pulsed for one cycle while gnt = 8'h02 and req = 8'h06.
  - Required response: gnt = 0 after the reset edge. The next grant after reset deasserts goes to master 1 (ptr = 0).
- Timeout (with RR_ARBITER8_TIMEOUT_EN, MAX_HOLD = 4):
  - Stimulus: req = 8'h03 held high.
  - Required response: gnt alternates 8'h01 and 8'h02, each owner holding for exactly 4 cycles.
  - With req = 8'h01 alone, gnt stays 8'h01 indefinitely.
  - Without the macro, under req = 8'h03 held high, gnt stays 8'h01 indefinitely.
